// File: rtl/rom_read_cache.sv
// Direct-mapped 16 x 16-bit read cache in front of the SDRAM ROM port. Hits answer next cycle with no stall; misses and loader writes hold cpu_busy until the controller's toggle ack.
// Define ROM_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module rom_read_cache #(
   parameter int LINE_BITS  = 4,
   parameter int DATA_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] cpu_addr,
   input  logic        cpu_rd,
   output logic [7:0]  cpu_dout,
   output logic        cpu_busy,
   input  logic [23:0] ld_addr,
   input  logic [15:0] ld_din,
   input  logic        ld_wr,
   output logic [22:0] rom_addr,
   output logic [15:0] rom_din,
   output logic        rom_we,
   output logic        rom_req,
   input  logic        rom_req_ack,
   input  logic [15:0] rom_dout
`ifdef ROM_CACHE_STATS_EN
   ,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
`endif
);

   localparam int ENTRIES = 1 << LINE_BITS;
   localparam int TAG_W   = 23 - LINE_BITS;
   localparam int CNT_W   = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;
   localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DATA_DELAY - 1);

   typedef enum logic [1:0] {IDLE, RD_ACK, RD_DATA, WR_ACK} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     dly_cnt;
   logic [ENTRIES-1:0]   valid;
   logic [TAG_W-1:0]     tag_mem  [ENTRIES];
   logic [15:0]          data_mem [ENTRIES];
   logic                 rd_byte;

   logic                 start_rd, start_wr, hit_rd, fill;
   logic                 req_idle, hit;
   logic [LINE_BITS-1:0] rd_idx, ld_idx, fill_idx;
   logic [TAG_W-1:0]     rd_tag, ld_tag, fill_tag;
   logic                 ld_addr_unused;

   assign rd_idx   = cpu_addr[LINE_BITS:1];
   assign rd_tag   = cpu_addr[23:LINE_BITS+1];
   assign ld_idx   = ld_addr[LINE_BITS:1];
   assign ld_tag   = ld_addr[23:LINE_BITS+1];
   // The in-flight word address already holds the fill index and tag.
   assign fill_idx = rom_addr[LINE_BITS-1:0];
   assign fill_tag = rom_addr[22:LINE_BITS];
   assign req_idle = (rom_req == rom_req_ack);
   assign hit      = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   assign ld_addr_unused = ld_addr[0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      hit_rd    = 1'b0;
      fill      = 1'b0;
      case (state)
         IDLE: begin
            if (ld_wr) begin
               if (req_idle) begin
                  start_wr  = 1'b1;
                  state_nxt = WR_ACK;
               end
            end else if (cpu_rd && hit) begin
               hit_rd = 1'b1;
            end else if (cpu_rd && req_idle) begin
               start_rd  = 1'b1;
               state_nxt = RD_ACK;
            end
         end
         RD_ACK:  if (req_idle) state_nxt = RD_DATA;
         RD_DATA: begin
            if (dly_cnt == '0) begin
               fill      = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR_ACK:  if (req_idle) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_req  <= 1'b0;
         rom_we   <= 1'b0;
         rom_addr <= '0;
         rom_din  <= '0;
         cpu_dout <= '0;
         cpu_busy <= 1'b0;
         valid    <= '0;
         dly_cnt  <= '0;
         rd_byte  <= 1'b0;
      end else begin
         if (start_rd || start_wr) begin
            rom_req  <= ~rom_req;
            cpu_busy <= 1'b1;
         end
         if (start_rd) begin
            rom_addr <= cpu_addr[23:1];
            rom_we   <= 1'b0;
            rd_byte  <= cpu_addr[0];
         end
         if (start_wr) begin
            rom_addr <= ld_addr[23:1];
            rom_din  <= ld_din;
            rom_we   <= 1'b1;
            if (tag_mem[ld_idx] == ld_tag) valid[ld_idx] <= 1'b0;
         end
         if (hit_rd) cpu_dout <= cpu_addr[0] ? data_mem[rd_idx][15:8] : data_mem[rd_idx][7:0];
         // Ack marks the CAS slot; read data lands DATA_DELAY cycles later.
         if (state == RD_ACK && req_idle)
            dly_cnt <= DLY_LOAD;
         else if (state == RD_DATA && dly_cnt != '0)
            dly_cnt <= dly_cnt - CNT_W'(1);
         if (fill) begin
            valid[fill_idx] <= 1'b1;
            cpu_dout        <= rd_byte ? rom_dout[15:8] : rom_dout[7:0];
            cpu_busy        <= 1'b0;
         end
         if (state == WR_ACK && req_idle) cpu_busy <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         data_mem[fill_idx] <= rom_dout;
         tag_mem[fill_idx]  <= fill_tag;
      end
   end

`ifdef ROM_CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_rd && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
         if (start_rd && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rom_read_cache.sv
// Scoreboard bench for rom_read_cache against a toggle req/ack SDRAM controller model.
module tb_rom_read_cache;

   localparam int DATA_DELAY = 4;
   localparam int ACK_WAIT   = 3;
   // Toggle-to-ack is one observe cycle plus ACK_WAIT; completion adds DATA_DELAY + 1.
   localparam int MISS_LAT   = (1 + ACK_WAIT) + DATA_DELAY + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] cpu_addr = '0;
   logic        cpu_rd = 1'b0;
   logic [7:0]  cpu_dout;
   logic        cpu_busy;
   logic [23:0] ld_addr = '0;
   logic [15:0] ld_din = '0;
   logic        ld_wr = 1'b0;
   logic [22:0] rom_addr;
   logic [15:0] rom_din;
   logic        rom_we;
   logic        rom_req;
   logic        ack_r;
   logic [15:0] dout_r;
`ifdef ROM_CACHE_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   rom_read_cache #(.LINE_BITS(4), .DATA_DELAY(DATA_DELAY)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
      .ld_addr(ld_addr), .ld_din(ld_din), .ld_wr(ld_wr),
      .rom_addr(rom_addr), .rom_din(rom_din), .rom_we(rom_we), .rom_req(rom_req),
      .rom_req_ack(ack_r), .rom_dout(dout_r)
`ifdef ROM_CACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  last_byte = 8'h00;
   logic [15:0] mem [int];

   function automatic logic [15:0] mem_word(input logic [22:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return {a[7:0], ~a[7:0]};
   endfunction

   // Controller model: acks ACK_WAIT cycles after seeing a request, shows stale data until DATA_DELAY after ack.
   int          req_cnt = 0;
   int          lat_cnt = 0;
   int          dly_cnt = 0;
   bit          active = 1'b0;
   logic [22:0] m_addr;
   logic        m_we;
   logic [15:0] m_din;

   always @(posedge clk) begin
      if (reset) begin
         ack_r   <= 1'b0;
         dout_r  <= 16'hDEAD;
         active  = 1'b0;
         lat_cnt = 0;
         dly_cnt = 0;
      end else begin
         if (dly_cnt > 0) begin
            dly_cnt = dly_cnt - 1;
            if (dly_cnt == 0) dout_r <= mem_word(m_addr);
         end
         if (active) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
               ack_r  <= ~ack_r;
               active = 1'b0;
               if (m_we) mem[int'(m_addr)] = m_din;
               else begin
                  dout_r  <= 16'hDEAD;
                  dly_cnt = DATA_DELAY;
               end
            end
         end else if (rom_req !== ack_r) begin
            active  = 1'b1;
            lat_cnt = ACK_WAIT;
            m_addr  = rom_addr;
            m_we    = rom_we;
            m_din   = rom_din;
            req_cnt++;
         end
      end
   end

   task automatic do_read(input logic [23:0] a, input bit exp_hit, input string nm, output int lat);
      int r0;
      logic [15:0] w;
      logic [7:0] e;
      w = mem_word(a[23:1]);
      exp_q.push_back(a[0] ? w[15:8] : w[7:0]);
      r0 = req_cnt;
      @(negedge clk); cpu_addr = a; cpu_rd = 1'b1;
      @(negedge clk); cpu_rd = 1'b0;
      checks++;
      if (cpu_busy !== !exp_hit) begin
         errors++; $display("FAIL %s busy_after_strobe got %b want %b", nm, cpu_busy, !exp_hit);
      end
      if (!exp_hit) begin
         checks++;
         if (rom_we !== 1'b0 || rom_addr !== a[23:1]) begin
            errors++; $display("FAIL %s rom_req_fields got we=%b addr=%h want we=0 addr=%h", nm, rom_we, rom_addr, a[23:1]);
         end
      end
      lat = 0;
      while (cpu_busy === 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      if (lat >= 60) begin
         checks++; errors++; $display("FAIL %s timeout busy still %b want 0", nm, cpu_busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (cpu_dout !== e) begin
         errors++; $display("FAIL %s cpu_dout got %h want %h", nm, cpu_dout, e);
      end
      checks++;
      if (req_cnt - r0 !== (exp_hit ? 0 : 1)) begin
         errors++; $display("FAIL %s req_count got %0d want %0d", nm, req_cnt - r0, exp_hit ? 0 : 1);
      end
      last_byte = e;
   endtask

   task automatic do_write(input logic [23:0] a, input logic [15:0] d, input string nm);
      int r0, n;
      r0 = req_cnt;
      @(negedge clk); ld_addr = a; ld_din = d; ld_wr = 1'b1;
      @(negedge clk); ld_wr = 1'b0;
      checks++;
      if (cpu_busy !== 1'b1 || rom_we !== 1'b1 || rom_din !== d || rom_addr !== a[23:1]) begin
         errors++; $display("FAIL %s wr_fields got busy=%b we=%b din=%h addr=%h want 1 1 %h %h",
                            nm, cpu_busy, rom_we, rom_din, rom_addr, d, a[23:1]);
      end
      n = 0;
      while (cpu_busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
      checks++;
      if (n >= 60 || req_cnt - r0 != 1) begin
         errors++; $display("FAIL %s wr_complete got busy=%b reqs=%0d want 0 1", nm, cpu_busy, req_cnt - r0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rom_req !== 1'b0 || rom_we !== 1'b0 || rom_addr !== 23'h0 || rom_din !== 16'h0) begin
         errors++; $display("FAIL reset_rom got req=%b we=%b addr=%h din=%h want 0 0 0 0", rom_req, rom_we, rom_addr, rom_din);
      end
      checks++;
      if (cpu_dout !== 8'h00 || cpu_busy !== 1'b0) begin
         errors++; $display("FAIL reset_cpu got dout=%h busy=%b want 00 0", cpu_dout, cpu_busy);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cold_read();
      int lat;
      do_read(24'h000010, 1'b0, "cold_read", lat);
      checks++;
      if (lat != MISS_LAT) begin
         errors++; $display("FAIL cold_latency got %0d want %0d", lat, MISS_LAT);
      end
   endtask

   task automatic test_hit();
      int lat;
      do_read(24'h000011, 1'b1, "hit_hi", lat);
      do_read(24'h000010, 1'b1, "hit_lo", lat);
   endtask

   task automatic test_conflict();
      int lat;
      do_read(24'h000030, 1'b0, "conflict_miss", lat);
      do_read(24'h000031, 1'b1, "conflict_hit", lat);
      do_read(24'h000010, 1'b0, "conflict_evicted", lat);
   endtask

   task automatic test_write_invalidate();
      int lat;
      do_write(24'h000010, 16'h1234, "wr_match");
      do_read(24'h000010, 1'b0, "wr_inval_miss", lat);
      do_read(24'h000011, 1'b1, "wr_inval_hit", lat);
      do_write(24'h000030, 16'h0BAD, "wr_other_tag");
      do_read(24'h000010, 1'b1, "wr_no_inval", lat);
   endtask

   task automatic test_timing_guard();
      int lat;
      do_read(24'h000200, 1'b0, "guard_miss", lat);
      do_read(24'h000201, 1'b1, "guard_stored", lat);
   endtask

   task automatic test_busy_ignore();
      int r0, n;
      logic [15:0] w;
      logic [7:0] e;
      w = mem_word(23'h000300);
      exp_q.push_back(w[7:0]);
      r0 = req_cnt;
      @(negedge clk); cpu_addr = 24'h000600; cpu_rd = 1'b1;
      @(negedge clk); cpu_addr = 24'h000010; ld_addr = 24'h000010; ld_din = 16'h5555; ld_wr = 1'b1;
      @(negedge clk); cpu_rd = 1'b0; ld_wr = 1'b0;
      checks++;
      if (rom_addr !== 23'h000300 || rom_we !== 1'b0) begin
         errors++; $display("FAIL busy_ignore_fields got addr=%h we=%b want 000300 0", rom_addr, rom_we);
      end
      n = 0;
      while (cpu_busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      checks++;
      if (n >= 60 || cpu_dout !== e || req_cnt - r0 != 1) begin
         errors++; $display("FAIL busy_ignore_done got dout=%h reqs=%0d busy=%b want %h 1 0", cpu_dout, req_cnt - r0, cpu_busy, e);
      end
      last_byte = e;
      do_read(24'h000011, 1'b1, "busy_ignore_entry_kept", n);
   endtask

   task automatic test_collision();
      int r0, n;
      r0 = req_cnt;
      @(negedge clk); cpu_addr = 24'h000200; cpu_rd = 1'b1; ld_addr = 24'h000040; ld_din = 16'h7777; ld_wr = 1'b1;
      @(negedge clk); cpu_rd = 1'b0; ld_wr = 1'b0;
      checks++;
      if (rom_we !== 1'b1 || rom_addr !== 23'h000020 || rom_din !== 16'h7777) begin
         errors++; $display("FAIL collision_wr_wins got we=%b addr=%h din=%h want 1 000020 7777", rom_we, rom_addr, rom_din);
      end
      n = 0;
      while (cpu_busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
      checks++;
      if (n >= 60 || cpu_dout !== last_byte || req_cnt - r0 != 1) begin
         errors++; $display("FAIL collision_done got dout=%h reqs=%0d want %h 1", cpu_dout, req_cnt - r0, last_byte);
      end
   endtask

   task automatic test_wrap();
      int lat;
      do_read(24'hFFFFFF, 1'b0, "wrap_miss", lat);
      do_read(24'hFFFFFE, 1'b1, "wrap_hit", lat);
   endtask

   task automatic test_reset_mid_miss();
      int n, lat;
      exp_q.push_back(8'h00);
      @(negedge clk); cpu_addr = 24'h000400; cpu_rd = 1'b1;
      @(negedge clk); cpu_rd = 1'b0;
      n = 0;
      while (ack_r !== rom_req && n < 60) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      checks++;
      if (n >= 60 || cpu_busy !== 1'b1) begin
         errors++; $display("FAIL mid_miss_setup got busy=%b wait=%0d want 1", cpu_busy, n);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      void'(exp_q.pop_front());
      checks++;
      if (cpu_busy !== 1'b0 || rom_req !== 1'b0) begin
         errors++; $display("FAIL mid_miss_reset got busy=%b req=%b want 0 0", cpu_busy, rom_req);
      end
`ifdef ROM_CACHE_STATS_EN
      checks++;
      if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
         errors++; $display("FAIL stats_reset got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
      end
`endif
      @(negedge clk);
      do_read(24'h000011, 1'b0, "after_reset_old_entry", lat);
      do_read(24'h000400, 1'b0, "after_reset_same_addr", lat);
`ifdef ROM_CACHE_STATS_EN
      do_read(24'h000401, 1'b1, "after_reset_hit", lat);
      checks++;
      if (hit_cnt !== 16'd1 || miss_cnt !== 16'd2) begin
         errors++; $display("FAIL stats_count got hit=%0d miss=%0d want 1 2", hit_cnt, miss_cnt);
      end
`endif
   endtask

   initial begin
      mem[int'(23'h000008)] = 16'hBEEF;
      mem[int'(23'h000018)] = 16'h5A3C;
      mem[int'(23'h000100)] = 16'hCAFE;
      mem[int'(23'h7FFFFF)] = 16'h9876;
      test_reset();
      test_cold_read();
      test_hit();
      test_conflict();
      test_write_invalidate();
      test_timing_guard();
      test_busy_ignore();
      test_collision();
      test_wrap();
      test_reset_mid_miss();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
